// File: rtl/port_mux_sched.sv
// Select scheduler for the two-input packet mux (generator = input 0, pass-through = input 1).
// Latency: select is registered (1 cycle); the mux's active input follows at the next EOP or idle cycle.
// Backpressure: none; monitor-only on the mux write strobes, request inputs only steer select.
//
// Ports:
//   clk, reset               clock; synchronous active-high reset
//   in_wr_0/1, in_ctrl_0/1   word strobe and ctrl field seen by each mux input (observed only)
//   req_0/1                  per-input packet-pending request
//   sched_en, force_sel      weighted round-robin enable, or fixed select when disabled
//   weight_0/1               packets per turn for each input (0 behaves as 1)
//   select                   registered mux select
//   cur_input                shadow of the mux's active input
//   turn_cnt                 packets started in the current turn (saturating)
//   pkt_cnt_0/1, word_cnt_0/1  statistics, present only when PORT_SCHED_STATS_EN is defined
//
// Build option: define PORT_SCHED_STATS_EN to add the per-input packet/word counters.

module port_mux_sched #(
    parameter int CTRL_WIDTH   = 8,
    parameter int WEIGHT_WIDTH = 8
`ifdef PORT_SCHED_STATS_EN
    ,
    parameter int STAT_WIDTH   = 32
`endif
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_wr_0,
    input  logic [CTRL_WIDTH-1:0]   in_ctrl_0,
    input  logic                    in_wr_1,
    input  logic [CTRL_WIDTH-1:0]   in_ctrl_1,
    input  logic                    req_0,
    input  logic                    req_1,
    input  logic                    sched_en,
    input  logic                    force_sel,
    input  logic [WEIGHT_WIDTH-1:0] weight_0,
    input  logic [WEIGHT_WIDTH-1:0] weight_1,
    output logic                    select,
    output logic                    cur_input,
    output logic [WEIGHT_WIDTH-1:0] turn_cnt
`ifdef PORT_SCHED_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0]   pkt_cnt_0,
    output logic [STAT_WIDTH-1:0]   pkt_cnt_1,
    output logic [STAT_WIDTH-1:0]   word_cnt_0,
    output logic [STAT_WIDTH-1:0]   word_cnt_1
`endif
);

    // Shadow of the mux's packet parser: header words carry nonzero ctrl,
    // the first zero-ctrl word enters the payload, the next nonzero ctrl word ends it.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDRS = 2'd1,
        PKT  = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;

    logic                    w;
    logic [CTRL_WIDTH-1:0]   c;
    logic                    sop;
    logic                    eop;
    logic                    sw;
    logic                    cur_nxt;
    logic [WEIGHT_WIDTH-1:0] turn_nxt;
    logic                    select_nxt;

    logic [WEIGHT_WIDTH-1:0] wt_raw;
    logic [WEIGHT_WIDTH-1:0] wt_eff;
    logic                    req_cur;
    logic                    req_oth;
    logic                    idle_gap;

    // Only the active input's strobe and ctrl matter to the mux parser.
    always_comb begin
        w = in_wr_0;
        c = in_ctrl_0;
        if (cur_input) begin
            w = in_wr_1;
            c = in_ctrl_1;
        end
    end

    // Parser next state. A switch is only legal with no packet in flight:
    // either an idle cycle without a new SOP, or the EOP cycle itself.
    always_comb begin
        state_nxt = state;
        sop       = 1'b0;
        eop       = 1'b0;
        sw        = 1'b0;
        case (state)
            IDLE: begin
                if (w) begin
                    state_nxt = HDRS;
                    sop       = 1'b1;
                end else if (select != cur_input) begin
                    sw = 1'b1;
                end
            end
            HDRS: begin
                if (w && (c == '0)) begin
                    state_nxt = PKT;
                end
            end
            PKT: begin
                if (w && (c != '0)) begin
                    state_nxt = IDLE;
                    eop       = 1'b1;
                    sw        = (select != cur_input);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Active input and turn counter follow the parser; a new turn starts at zero.
    always_comb begin
        cur_nxt  = cur_input;
        turn_nxt = turn_cnt;
        if (sw) begin
            cur_nxt  = select;
            turn_nxt = '0;
        end else if (sop && (turn_cnt != {WEIGHT_WIDTH{1'b1}})) begin
            turn_nxt = turn_cnt + 1'b1;
        end
    end

    // Scheduling inputs seen from the currently active side.
    always_comb begin
        wt_raw  = cur_input ? weight_1 : weight_0;
        req_cur = cur_input ? req_1 : req_0;
        req_oth = cur_input ? req_0 : req_1;
    end

    assign wt_eff   = (wt_raw == '0) ? {{(WEIGHT_WIDTH-1){1'b0}}, 1'b1} : wt_raw;

    // The active input is truly idle: parser between packets, no SOP now, nothing queued.
    assign idle_gap = (state == IDLE) && !w && !req_cur;

    // Select policy. Once select differs from cur_input the request is committed
    // and held until the mux follows, even if the other side stops requesting.
    // The turn check uses the post-update count so select flips on the SOP edge
    // of the last packet of the turn, giving the mux the whole packet to follow.
    always_comb begin
        select_nxt = select;
        if (!sched_en) begin
            select_nxt = force_sel;
        end else if (select == cur_input) begin
            if (req_oth && ((turn_nxt >= wt_eff) || idle_gap)) begin
                select_nxt = ~cur_input;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cur_input <= 1'b0;
            turn_cnt  <= '0;
            select    <= 1'b0;
        end else begin
            state     <= state_nxt;
            cur_input <= cur_nxt;
            turn_cnt  <= turn_nxt;
            select    <= select_nxt;
        end
    end

`ifdef PORT_SCHED_STATS_EN
    // Counters are attributed to the input active during the word; they wrap freely.
    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_cnt_0  <= '0;
            pkt_cnt_1  <= '0;
            word_cnt_0 <= '0;
            word_cnt_1 <= '0;
        end else begin
            if (eop && !cur_input) begin
                pkt_cnt_0 <= pkt_cnt_0 + 1'b1;
            end
            if (eop && cur_input) begin
                pkt_cnt_1 <= pkt_cnt_1 + 1'b1;
            end
            if (w && !cur_input) begin
                word_cnt_0 <= word_cnt_0 + 1'b1;
            end
            if (w && cur_input) begin
                word_cnt_1 <= word_cnt_1 + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_port_mux_sched.sv
// Self-checking bench for port_mux_sched.
// Sources drive packets on whichever input the scheduler's shadow says is active;
// the other input carries random noise that the scheduler must ignore.
module tb_port_mux_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_wr_0;
    logic [7:0] in_ctrl_0;
    logic       in_wr_1;
    logic [7:0] in_ctrl_1;
    logic       req_0;
    logic       req_1;
    logic       sched_en;
    logic       force_sel;
    logic [7:0] weight_0;
    logic [7:0] weight_1;
    logic       select;
    logic       cur_input;
    logic [7:0] turn_cnt;
`ifdef PORT_SCHED_STATS_EN
    logic [31:0] pkt_cnt_0;
    logic [31:0] pkt_cnt_1;
    logic [31:0] word_cnt_0;
    logic [31:0] word_cnt_1;
`endif

    port_mux_sched dut (
        .clk        (clk),
        .reset      (reset),
        .in_wr_0    (in_wr_0),
        .in_ctrl_0  (in_ctrl_0),
        .in_wr_1    (in_wr_1),
        .in_ctrl_1  (in_ctrl_1),
        .req_0      (req_0),
        .req_1      (req_1),
        .sched_en   (sched_en),
        .force_sel  (force_sel),
        .weight_0   (weight_0),
        .weight_1   (weight_1),
        .select     (select),
        .cur_input  (cur_input),
        .turn_cnt   (turn_cnt)
`ifdef PORT_SCHED_STATS_EN
        ,
        .pkt_cnt_0  (pkt_cnt_0),
        .pkt_cnt_1  (pkt_cnt_1),
        .word_cnt_0 (word_cnt_0),
        .word_cnt_1 (word_cnt_1)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Source state: packets still to send, packet length, next word index.
    int pkts_left[2];
    int plen[2];
    int pos[2];
    bit req_extra[2];

    // Scoreboard of expected input index for each packet start.
    int exp_q[$];

    int test_id;
    int sop0;
    bit sel_rise_pending;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one cycle of inputs; called once per cycle after sampling.
    task automatic drive_inputs();
        int x;
        int y;
        logic wv[2];
        logic [7:0] cv[2];
        x = cur_input ? 1 : 0;
        y = 1 - x;
        wv[y] = 1'($urandom_range(0, 1));
        cv[y] = 8'($urandom_range(0, 255));
        wv[x] = 1'b0;
        cv[x] = 8'($urandom_range(0, 255));
        if (pkts_left[x] != 0) begin
            wv[x] = 1'b1;
            if (pos[x] == 0) begin
                cv[x] = 8'hFF;
                if (exp_q.size() == 0) begin
                    check_val("sb_unexpected_sop", 32'(x), 32'hFFFF_FFFF);
                end else begin
                    check_val("sb_order", 32'(x), 32'(exp_q.pop_front()));
                end
                if (test_id == 1 && x == 0) begin
                    sop0++;
                    if (sop0 == 2 || sop0 == 4) begin
                        check_val("t1_sel_pre", 32'(select), 32'd0);
                        sel_rise_pending = 1'b1;
                    end
                end
            end else if (pos[x] == plen[x] - 1) begin
                cv[x] = 8'h10;
            end else begin
                cv[x] = 8'h00;
            end
            pos[x]++;
            if (pos[x] == plen[x]) begin
                pos[x] = 0;
                pkts_left[x]--;
            end
        end
        in_wr_0   = wv[0];
        in_ctrl_0 = cv[0];
        in_wr_1   = wv[1];
        in_ctrl_1 = cv[1];
        req_0     = (pkts_left[0] != 0) || req_extra[0];
        req_1     = (pkts_left[1] != 0) || req_extra[1];
    endtask

    // Runs sources until all packets are sent; inputs for the current cycle already driven.
    task automatic run_until_done(input string tag, input int bound);
        int n;
        n = 0;
        while ((pkts_left[0] != 0 || pkts_left[1] != 0) && n < bound) begin
            tick();
            if (sel_rise_pending) begin
                check_val("t1_sel_rise", 32'(select), 32'd1);
                sel_rise_pending = 1'b0;
            end
            drive_inputs();
            n++;
        end
        tick();
        check_val({tag, "_in_time"}, 32'(n < bound), 32'd1);
        check_val({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        reset     = 1'b1;
        pkts_left = '{0, 0};
        pos       = '{0, 0};
        plen      = '{4, 4};
        req_extra = '{1'b0, 1'b0};
        exp_q.delete();
        in_wr_0   = 1'b0;
        in_ctrl_0 = 8'h00;
        in_wr_1   = 1'b0;
        in_ctrl_1 = 8'h00;
        req_0     = 1'b0;
        req_1     = 1'b0;
        sched_en  = 1'b1;
        force_sel = 1'b0;
        weight_0  = 8'd1;
        weight_1  = 8'd1;
        test_id   = 0;
        sop0      = 0;
        sel_rise_pending = 1'b0;
        tick();
        tick();
        check_val({tag, "_select"}, 32'(select), 32'd0);
        check_val({tag, "_cur"}, 32'(cur_input), 32'd0);
        check_val({tag, "_turn"}, 32'(turn_cnt), 32'd0);
`ifdef PORT_SCHED_STATS_EN
        check_val({tag, "_pkt0"}, pkt_cnt_0, 32'd0);
        check_val({tag, "_pkt1"}, pkt_cnt_1, 32'd0);
        check_val({tag, "_word0"}, word_cnt_0, 32'd0);
        check_val({tag, "_word1"}, word_cnt_1, 32'd0);
`endif
        reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: weights 2/1, both requesting, 4-word packets.
        do_reset("rst1");
        test_id      = 1;
        weight_0     = 8'd2;
        weight_1     = 8'd1;
        pkts_left    = '{4, 2};
        plen         = '{4, 4};
        exp_q        = '{0, 0, 1, 0, 0, 1};
        drive_inputs();
        run_until_done("t1", 200);

        // 2: weight 0 behaves as 1 -> strict alternation.
        do_reset("rst2");
        weight_0  = 8'd0;
        weight_1  = 8'd1;
        pkts_left = '{2, 2};
        plen      = '{4, 4};
        exp_q     = '{0, 1, 0, 1};
        drive_inputs();
        run_until_done("t2", 200);

        // 3: idle, nobody requesting, then input 1 requests.
        do_reset("rst3");
        drive_inputs();
        for (int i = 0; i < 5; i++) begin
            tick();
            drive_inputs();
        end
        check_val("t3_none_sel", 32'(select), 32'd0);
        check_val("t3_none_cur", 32'(cur_input), 32'd0);
        req_extra[1] = 1'b1;
        drive_inputs();
        tick();
        check_val("t3_sel_t1", 32'(select), 32'd1);
        check_val("t3_cur_t1", 32'(cur_input), 32'd0);
        drive_inputs();
        tick();
        check_val("t3_cur_t2", 32'(cur_input), 32'd1);
        check_val("t3_turn_t2", 32'(turn_cnt), 32'd0);

        // 4: forced select mid-packet; mux follows only after EOP.
        do_reset("rst4");
        sched_en     = 1'b0;
        pkts_left[0] = 1;
        plen[0]      = 6;
        exp_q        = '{0};
        drive_inputs();
        tick();
        force_sel = 1'b1;
        drive_inputs();
        tick();
        check_val("t4_sel", 32'(select), 32'd1);
        check_val("t4_cur_w2", 32'(cur_input), 32'd0);
        for (int i = 0; i < 4; i++) begin
            drive_inputs();
            tick();
            if (i < 3) begin
                check_val("t4_cur_mid", 32'(cur_input), 32'd0);
            end
        end
        check_val("t4_cur_after_eop", 32'(cur_input), 32'd1);

        // 5: committed switch survives a dropped request; input 0 then wins back.
        do_reset("rst5");
        pkts_left[0] = 2;
        plen[0]      = 6;
        req_extra[1] = 1'b1;
        exp_q        = '{0, 0};
        drive_inputs();
        tick();
        check_val("t5_sel_sop", 32'(select), 32'd1);
        req_extra[1] = 1'b0;
        drive_inputs();
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val("t5_sel_hold", 32'(select), 32'd1);
            check_val("t5_cur_hold", 32'(cur_input), 32'd0);
            drive_inputs();
        end
        tick();
        check_val("t5_cur_sw", 32'(cur_input), 32'd1);
        check_val("t5_turn_sw", 32'(turn_cnt), 32'd0);
        drive_inputs();
        tick();
        check_val("t5_sel_back", 32'(select), 32'd0);
        drive_inputs();
        tick();
        check_val("t5_cur_back", 32'(cur_input), 32'd0);
        drive_inputs();
        run_until_done("t5", 50);

        // 7: only the current input requests; keeps the mux, turn_cnt saturates.
        do_reset("rst7");
        pkts_left[0] = 257;
        plen[0]      = 3;
        for (int i = 0; i < 257; i++) begin
            exp_q.push_back(0);
        end
        drive_inputs();
        run_until_done("t7", 1000);
        check_val("t7_turn_sat", 32'(turn_cnt), 32'd255);
        check_val("t7_sel", 32'(select), 32'd0);
        check_val("t7_cur", 32'(cur_input), 32'd0);

`ifdef PORT_SCHED_STATS_EN
        // 6: statistics, then reset mid-packet.
        do_reset("rst6");
        pkts_left[0] = 3;
        plen[0]      = 5;
        exp_q        = '{0, 0, 0};
        drive_inputs();
        run_until_done("t6", 100);
        check_val("t6_pkt0", pkt_cnt_0, 32'd3);
        check_val("t6_word0", word_cnt_0, 32'd15);
        check_val("t6_pkt1", pkt_cnt_1, 32'd0);
        check_val("t6_word1", word_cnt_1, 32'd0);
        pkts_left[0] = 1;
        exp_q        = '{0};
        drive_inputs();
        tick();
        drive_inputs();
        tick();
        check_val("t6_word_mid", word_cnt_0, 32'd17);
        do_reset("t6_rst_mid");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
